// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor.
// Computes a - b as a + ~b + 1 through one full-adder stage and a registered
// carry, one difference bit per clock, LSB first, with a start/busy/done
// handshake. Results (diff, borrowout, overflow) hold until the next
// operation finishes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // One-hot so busy and done come straight off a flop.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    logic             c;
    logic             cmsb;
    logic [CW-1:0]    cnt;

    logic             nb;
    logic             s;
    logic             c_next;
    logic             last;
    logic             accept;
    logic             cmsb_next;

    // Single full-adder slice fed by the inverted subtrahend bit.
    always_comb begin
        nb        = ~rb[0];
        s         = ra[0] ^ nb ^ c;
        c_next    = (ra[0] & nb) | (ra[0] & c) | (nb & c);
        last      = (state == SHIFT) && (cnt == LAST);
        accept    = (state != SHIFT) && start;
        // Carry into the MSB stage is the carry present while the final bit
        // is processed; the overflow flag uses it on that same edge.
        cmsb_next = last ? c : cmsb;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the one-hot state flops.
    always_comb begin
        busy = state[1];
        done = state[2];
    end

    // Operand/result shift registers, carry, counter and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra        <= '0;
            rb        <= '0;
            rd        <= '0;
            c         <= 1'b0;
            cmsb      <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrowout <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ra  <= a;
            rb  <= b;
            c   <= 1'b1;
            cnt <= '0;
        end else if (state == SHIFT) begin
            ra   <= {1'b0, ra[WIDTH-1:1]};
            rb   <= {1'b0, rb[WIDTH-1:1]};
            rd   <= {s, rd[WIDTH-1:1]};
            c    <= c_next;
            cnt  <= cnt + 1'b1;
            cmsb <= cmsb_next;
            if (last) begin
                diff      <= {s, rd[WIDTH-1:1]};
                borrowout <= ~c_next;
                overflow  <= cmsb_next ^ c_next;
            end
        end
    end

endmodule
